// File: rtl/ysyx_25040105_idu_stage.sv
// RV32I instruction-decode stage: combinational decode of the incoming word,
// registered output entry plus one skid entry, valid/ready on both sides,
// synchronous flush for redirects and a wrapping count of delivered beats.

package ysyx_25040105_idu_pkg;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned ALUOP_W = 4;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [31:0] INST_EBREAK = 32'h00100073;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SRL   = 4'd3;
    localparam logic [3:0] ALU_AUIPC = 4'd4;
    localparam logic [3:0] ALU_LUI   = 4'd5;
    localparam logic [3:0] ALU_JAL   = 4'd6;
    localparam logic [3:0] ALU_JALR  = 4'd7;
    localparam logic [3:0] ALU_SRA   = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_OR    = 4'd10;
    localparam logic [3:0] ALU_XOR   = 4'd11;
    localparam logic [3:0] ALU_SLT   = 4'd12;
    localparam logic [3:0] ALU_SLTU  = 4'd13;

    // Decoded control payload carried alongside pc/imm in each buffer entry.
    typedef struct packed {
        logic [REG_W-1:0]   rs1;
        logic [REG_W-1:0]   rs2;
        logic [REG_W-1:0]   rd;
        logic [2:0]         funct3;
        logic [ALUOP_W-1:0] alu_op;
        logic               alu_src;
        logic               reg_wen;
        logic               mem_ren;
        logic               mem_wen;
        logic               branch;
        logic               jump_en;
        logic               ebreak;
        logic               illegal;
    } dec_t;

endpackage

module ysyx_25040105_idu_stage
    import ysyx_25040105_idu_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned SKID_EN = 1,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rd,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_funct3,
    output logic [3:0]       out_alu_op,
    output logic             out_alu_src,
    output logic             out_reg_wen,
    output logic             out_mem_ren,
    output logic             out_mem_wen,
    output logic             out_branch,
    output logic             out_jump_en,
    output logic             out_ebreak,
    output logic             out_illegal,
    output logic [CNT_W-1:0] dec_count
);

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic             r_live;
    logic [XLEN-1:0]  r_pc0, r_pc1, r_imm0, r_imm1;
    dec_t             r_dec0, r_dec1;
    logic [CNT_W-1:0] r_cnt;

    dec_t             w_dec;
    logic [31:0]      w_imm32;
    logic [XLEN-1:0]  w_imm;
    logic [6:0]       w_f7;
    logic             w_acc, w_pop;
    logic             w_ld0_in, w_ld0_skid, w_ld1;

    assign w_f7  = in_inst[31:25];
    assign w_imm = XLEN'($signed(w_imm32));

    // Operation selected by funct3 when funct7 carries no modifier.
    function automatic logic [3:0] base_op(input logic [2:0] f3);
        case (f3)
            3'd0:    base_op = ALU_ADD;
            3'd1:    base_op = ALU_SLL;
            3'd2:    base_op = ALU_SLT;
            3'd3:    base_op = ALU_SLTU;
            3'd4:    base_op = ALU_XOR;
            3'd5:    base_op = ALU_SRL;
            3'd6:    base_op = ALU_OR;
            default: base_op = ALU_AND;
        endcase
    endfunction

    // Combinational decode of the word currently on the input port.
    always_comb begin
        w_dec        = '0;
        w_imm32      = '0;
        w_dec.rs1    = in_inst[19:15];
        w_dec.rs2    = in_inst[24:20];
        w_dec.rd     = in_inst[11:7];
        w_dec.funct3 = in_inst[14:12];
        case (in_inst[6:0])
            OPC_LUI, OPC_AUIPC: begin
                w_dec.reg_wen = 1'b1;
                w_dec.alu_src = 1'b1;
                w_dec.alu_op  = (in_inst[6:0] == OPC_LUI) ? ALU_LUI : ALU_AUIPC;
                w_imm32       = {in_inst[31:12], 12'b0};
            end
            OPC_JAL: begin
                w_dec.reg_wen = 1'b1;
                w_dec.jump_en = 1'b1;
                w_dec.alu_src = 1'b1;
                w_dec.alu_op  = ALU_JAL;
                w_imm32 = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
            end
            OPC_JALR: begin
                w_dec.reg_wen = 1'b1;
                w_dec.jump_en = 1'b1;
                w_dec.alu_src = 1'b1;
                w_dec.alu_op  = ALU_JALR;
                w_dec.illegal = (in_inst[14:12] != 3'd0);
                w_imm32       = {{20{in_inst[31]}}, in_inst[31:20]};
            end
            OPC_BRANCH: begin
                w_dec.branch  = 1'b1;
                w_dec.alu_op  = ALU_SUB;
                w_dec.illegal = (in_inst[14:13] == 2'b01);
                w_imm32 = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
            end
            OPC_LOAD: begin
                w_dec.reg_wen = 1'b1;
                w_dec.mem_ren = 1'b1;
                w_dec.alu_src = 1'b1;
                w_imm32       = {{20{in_inst[31]}}, in_inst[31:20]};
            end
            OPC_STORE: begin
                w_dec.mem_wen = 1'b1;
                w_dec.alu_src = 1'b1;
                w_imm32       = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            end
            OPC_OP_IMM: begin
                w_dec.reg_wen = 1'b1;
                w_dec.alu_src = 1'b1;
                w_dec.alu_op  = base_op(in_inst[14:12]);
                w_imm32       = {{20{in_inst[31]}}, in_inst[31:20]};
                if (in_inst[14:12] == 3'd1) begin
                    w_dec.illegal = (w_f7 != 7'h00);
                end else if (in_inst[14:12] == 3'd5) begin
                    if (w_f7 == 7'h20)      w_dec.alu_op  = ALU_SRA;
                    else if (w_f7 != 7'h00) w_dec.illegal = 1'b1;
                end
            end
            OPC_OP: begin
                w_dec.reg_wen = 1'b1;
                w_dec.alu_op  = base_op(in_inst[14:12]);
                if (w_f7 == 7'h20) begin
                    if (in_inst[14:12] == 3'd0)      w_dec.alu_op  = ALU_SUB;
                    else if (in_inst[14:12] == 3'd5) w_dec.alu_op  = ALU_SRA;
                    else                             w_dec.illegal = 1'b1;
                end else if (w_f7 != 7'h00) begin
                    w_dec.illegal = 1'b1;
                end
            end
            OPC_MISC_MEM: begin
                w_dec.illegal = 1'b0;
            end
            OPC_SYSTEM: begin
                w_dec.ebreak  = (in_inst == INST_EBREAK);
                w_dec.illegal = (in_inst != INST_EBREAK);
            end
            default: begin
                w_dec.illegal = 1'b1;
            end
        endcase
        // Trapping beats must not write or touch memory downstream.
        if (w_dec.illegal || w_dec.ebreak) begin
            w_dec.reg_wen = 1'b0;
            w_dec.mem_ren = 1'b0;
            w_dec.mem_wen = 1'b0;
            w_dec.branch  = 1'b0;
            w_dec.jump_en = 1'b0;
            w_dec.alu_src = 1'b0;
            w_dec.alu_op  = ALU_ADD;
            w_imm32       = '0;
        end
    end

    assign out_valid = (r_state != S_EMPTY);
    assign in_ready  = (SKID_EN != 0) ? (r_live && (r_state != S_TWO))
                                      : (r_live && (!out_valid || out_ready));
    assign w_acc     = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    // Occupancy state register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_EMPTY;
        else        r_state <= w_state_nx;
    end

    // Next occupancy and entry load selects; flush overrides everything.
    always_comb begin
        w_state_nx = r_state;
        w_ld0_in   = 1'b0;
        w_ld0_skid = 1'b0;
        w_ld1      = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_acc) begin
                    w_state_nx = S_ONE;
                    w_ld0_in   = 1'b1;
                end
            end
            S_ONE: begin
                if (w_acc && w_pop) begin
                    w_ld0_in   = 1'b1;
                end else if (w_pop) begin
                    w_state_nx = S_EMPTY;
                end else if (w_acc) begin
                    w_state_nx = S_TWO;
                    w_ld1      = 1'b1;
                end
            end
            S_TWO: begin
                if (w_pop) begin
                    w_state_nx = S_ONE;
                    w_ld0_skid = 1'b1;
                end
            end
            default: w_state_nx = S_EMPTY;
        endcase
        if (flush) begin
            w_state_nx = S_EMPTY;
            w_ld0_in   = 1'b0;
            w_ld0_skid = 1'b0;
            w_ld1      = 1'b0;
        end
    end

    // in_ready stays low until the first edge after reset release.
    always_ff @(posedge clk) begin
        if (!rst_n) r_live <= 1'b0;
        else        r_live <= 1'b1;
    end

    // Output entry and skid entry payload registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc0  <= '0;
            r_imm0 <= '0;
            r_dec0 <= '0;
            r_pc1  <= '0;
            r_imm1 <= '0;
            r_dec1 <= '0;
        end else begin
            if (w_ld0_in) begin
                r_pc0  <= in_pc;
                r_imm0 <= w_imm;
                r_dec0 <= w_dec;
            end else if (w_ld0_skid) begin
                r_pc0  <= r_pc1;
                r_imm0 <= r_imm1;
                r_dec0 <= r_dec1;
            end
            if (w_ld1) begin
                r_pc1  <= in_pc;
                r_imm1 <= w_imm;
                r_dec1 <= w_dec;
            end
        end
    end

    // Delivered-beat counter; flush does not clear it.
    always_ff @(posedge clk) begin
        if (!rst_n)     r_cnt <= '0;
        else if (w_pop) r_cnt <= r_cnt + CNT_W'(1);
    end

    assign dec_count   = r_cnt;
    assign out_pc      = r_pc0;
    assign out_imm     = r_imm0;
    assign out_rs1     = r_dec0.rs1;
    assign out_rs2     = r_dec0.rs2;
    assign out_rd      = r_dec0.rd;
    assign out_funct3  = r_dec0.funct3;
    assign out_alu_op  = r_dec0.alu_op;
    assign out_alu_src = r_dec0.alu_src;
    assign out_reg_wen = r_dec0.reg_wen;
    assign out_mem_ren = r_dec0.mem_ren;
    assign out_mem_wen = r_dec0.mem_wen;
    assign out_branch  = r_dec0.branch;
    assign out_jump_en = r_dec0.jump_en;
    assign out_ebreak  = r_dec0.ebreak;
    assign out_illegal = r_dec0.illegal;

endmodule

// File: tb/tb_ysyx_25040105_idu_stage.sv
// Bench for the decode stage: directed decode/handshake scenarios followed by
// random traffic checked against a queue-based reference model.

module tb_ysyx_25040105_idu_stage;

    localparam int unsigned TB_CNT_W = 4;

    logic        clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_inst, in_pc, out_pc, out_imm;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [2:0]  out_funct3;
    logic [3:0]  out_alu_op;
    logic        out_alu_src, out_reg_wen, out_mem_ren, out_mem_wen;
    logic        out_branch, out_jump_en, out_ebreak, out_illegal;
    logic [TB_CNT_W-1:0] dec_count;

    ysyx_25040105_idu_stage #(.XLEN(32), .SKID_EN(1), .CNT_W(TB_CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
        .out_funct3(out_funct3), .out_alu_op(out_alu_op), .out_alu_src(out_alu_src),
        .out_reg_wen(out_reg_wen), .out_mem_ren(out_mem_ren), .out_mem_wen(out_mem_wen),
        .out_branch(out_branch), .out_jump_en(out_jump_en), .out_ebreak(out_ebreak),
        .out_illegal(out_illegal), .dec_count(dec_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic [3:0]  op;
        logic        src, wen, ren, mwen, br, jmp, ebr, ill;
    } exp_t;

    typedef struct {
        logic [31:0] ins, imm;
        logic [3:0]  op;
        logic        src, wen, br, ebr, ill;
    } dir_t;

    int   n_total = 0;
    int   n_bad   = 0;
    exp_t q[$];
    int   cnt  = 0;
    bit   live = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference decode written directly from the RV32I instruction rules.
    function automatic exp_t model_dec(input logic [31:0] ins, input logic [31:0] pc);
        exp_t        e;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] ii, is, ib, iu, ij;
        logic [3:0]  f3_alu [8];
        f3_alu = '{4'd0, 4'd2, 4'd12, 4'd13, 4'd11, 4'd3, 4'd10, 4'd9};
        f3 = ins[14:12];
        f7 = ins[31:25];
        ii = $signed(ins) >>> 20;
        is = {ii[31:5], ins[11:7]};
        ib = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
        iu = ins & 32'hFFFFF000;
        ij = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
        e = '{default: '0};
        e.pc = pc; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7]; e.f3 = f3;
        case (ins[6:0])
            7'h37: begin e.wen = 1; e.src = 1; e.op = 4'd5; e.imm = iu; end
            7'h17: begin e.wen = 1; e.src = 1; e.op = 4'd4; e.imm = iu; end
            7'h6f: begin e.wen = 1; e.jmp = 1; e.src = 1; e.op = 4'd6; e.imm = ij; end
            7'h67: begin e.wen = 1; e.jmp = 1; e.src = 1; e.op = 4'd7; e.imm = ii; e.ill = (f3 != 0); end
            7'h63: begin e.br = 1; e.op = 4'd1; e.imm = ib; e.ill = (f3 == 2) || (f3 == 3); end
            7'h03: begin e.wen = 1; e.ren = 1; e.src = 1; e.imm = ii; end
            7'h23: begin e.mwen = 1; e.src = 1; e.imm = is; end
            7'h13: begin
                e.wen = 1; e.src = 1; e.imm = ii; e.op = f3_alu[f3];
                if (f3 == 1 && f7 != 0) e.ill = 1;
                if (f3 == 5) begin
                    if (f7 == 7'h20)   e.op  = 4'd8;
                    else if (f7 != 0)  e.ill = 1;
                end
            end
            7'h33: begin
                e.wen = 1; e.op = f3_alu[f3];
                if (f7 == 7'h20) begin
                    if (f3 == 0)      e.op  = 4'd1;
                    else if (f3 == 5) e.op  = 4'd8;
                    else              e.ill = 1;
                end else if (f7 != 0) e.ill = 1;
            end
            7'h0f: ;
            7'h73: begin
                if (ins == 32'h00100073) e.ebr = 1;
                else                     e.ill = 1;
            end
            default: e.ill = 1;
        endcase
        if (e.ill || e.ebr) begin
            e.op = 0; e.src = 0; e.wen = 0; e.ren = 0; e.mwen = 0;
            e.br = 0; e.jmp = 0; e.imm = 0;
        end
        return e;
    endfunction

    task automatic check_beat(input exp_t e);
        chk("pc",      64'(out_pc),      64'(e.pc));
        chk("imm",     64'(out_imm),     64'(e.imm));
        chk("rs1",     64'(out_rs1),     64'(e.rs1));
        chk("rs2",     64'(out_rs2),     64'(e.rs2));
        chk("rd",      64'(out_rd),      64'(e.rd));
        chk("funct3",  64'(out_funct3),  64'(e.f3));
        chk("alu_op",  64'(out_alu_op),  64'(e.op));
        chk("alu_src", 64'(out_alu_src), 64'(e.src));
        chk("reg_wen", 64'(out_reg_wen), 64'(e.wen));
        chk("mem_ren", 64'(out_mem_ren), 64'(e.ren));
        chk("mem_wen", 64'(out_mem_wen), 64'(e.mwen));
        chk("branch",  64'(out_branch),  64'(e.br));
        chk("jump_en", 64'(out_jump_en), 64'(e.jmp));
        chk("ebreak",  64'(out_ebreak),  64'(e.ebr));
        chk("illegal", 64'(out_illegal), 64'(e.ill));
    endtask

    // One clock: drive inputs, compare against the model, then advance both.
    task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic rdy, input logic fl);
        logic exp_ir, acc, pop;
        in_valid = v; in_inst = ins; in_pc = pc; out_ready = rdy; flush = fl;
        #1;
        exp_ir = live && (q.size() < 2);
        chk("in_ready",  64'(in_ready),  64'(exp_ir));
        chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
        chk("dec_count", 64'(dec_count), 64'(cnt % (1 << TB_CNT_W)));
        if (q.size() != 0) check_beat(q[0]);
        acc = v && exp_ir;
        pop = (q.size() != 0) && rdy;
        if (pop) cnt++;
        if (fl) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(model_dec(ins, pc));
        end
        live = 1;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0]  opcs [11];
        logic [31:0] r;
        int          k;
        opcs = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0f, 7'h73};
        r = $urandom;
        k = $urandom_range(0, 9);
        if (k < 6) r[6:0] = opcs[$urandom_range(0, 10)];
        if (k < 4) r[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        if (k == 6) r = 32'h00100073;
        if (k == 7) r[6:0] = 7'h3b;
        return r;
    endfunction

    dir_t dirs [12];

    initial begin
        dirs = '{
            '{32'h00500093, 32'h00000005, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0},
            '{32'h402081b3, 32'h00000000, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0},
            '{32'h4020d193, 32'h00000402, 4'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0},
            '{32'hfe000ee3, 32'hFFFFFFFC, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0},
            '{32'h00100073, 32'h00000000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0},
            '{32'h00000073, 32'h00000000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1},
            '{32'hFFFFFFFF, 32'h00000000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1},
            '{32'h02009093, 32'h00000000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1},
            '{32'h0000a063, 32'h00000000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1},
            '{32'h000090e7, 32'h00000000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1},
            '{32'h123452b7, 32'h12345000, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0},
            '{32'h008000ef, 32'h00000008, 4'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}
        };

        rst_n = 0; flush = 0; in_valid = 0; in_inst = '0; in_pc = '0; out_ready = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_in_ready",  64'(in_ready),  64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_dec_count", 64'(dec_count), 64'd0);
        chk("rst_out_pc",    64'(out_pc),    64'd0);
        chk("rst_out_imm",   64'(out_imm),   64'd0);
        chk("rst_alu_op",    64'(out_alu_op), 64'd0);
        rst_n = 1;

        // First cycle after release: in_ready still low.
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Backpressure: A and B fill both entries, C waits, then drain in order.
        cycle(1'b1, 32'h00500093, 32'h100, 1'b0, 1'b0);
        chk("abc_first_pc", 64'(out_pc), 64'h100);
        cycle(1'b1, 32'h402081b3, 32'h104, 1'b0, 1'b0);
        chk("abc_ready_after_b", 64'(in_ready), 64'd0);
        cycle(1'b1, 32'h4020d193, 32'h108, 1'b0, 1'b0);
        chk("abc_hold_pc", 64'(out_pc), 64'h100);
        cycle(1'b1, 32'h4020d193, 32'h108, 1'b1, 1'b0);
        chk("abc_second_pc", 64'(out_pc), 64'h104);
        cycle(1'b1, 32'h4020d193, 32'h108, 1'b1, 1'b0);
        chk("abc_third_pc", 64'(out_pc), 64'h108);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("abc_count", 64'(dec_count), 64'd3);
        chk("abc_empty", 64'(out_valid), 64'd0);

        // Flush while holding one beat with a new beat arriving.
        cycle(1'b1, 32'h00500093, 32'h200, 1'b0, 1'b0);
        cycle(1'b1, 32'h402081b3, 32'h204, 1'b0, 1'b1);
        chk("flush_empty", 64'(out_valid), 64'd0);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("flush_no_ghost", 64'(out_valid), 64'd0);
        chk("flush_count", 64'(dec_count), 64'd3);
        // Flush with out_ready: presented beat still counts.
        cycle(1'b1, 32'h00500093, 32'h300, 1'b0, 1'b0);
        cycle(1'b1, 32'h402081b3, 32'h304, 1'b1, 1'b1);
        chk("flush_pop_count", 64'(dec_count), 64'd4);
        chk("flush_pop_empty", 64'(out_valid), 64'd0);

        // Directed decode table.
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, dirs[i].ins, 32'h80000000, 1'b0, 1'b0);
            chk("dir_valid",   64'(out_valid),   64'd1);
            chk("dir_pc",      64'(out_pc),      64'h80000000);
            chk("dir_imm",     64'(out_imm),     64'(dirs[i].imm));
            chk("dir_alu_op",  64'(out_alu_op),  64'(dirs[i].op));
            chk("dir_alu_src", 64'(out_alu_src), 64'(dirs[i].src));
            chk("dir_reg_wen", 64'(out_reg_wen), 64'(dirs[i].wen));
            chk("dir_branch",  64'(out_branch),  64'(dirs[i].br));
            chk("dir_ebreak",  64'(out_ebreak),  64'(dirs[i].ebr));
            chk("dir_illegal", 64'(out_illegal), 64'(dirs[i].ill));
            chk("dir_mem",     64'({out_mem_ren, out_mem_wen}), 64'd0);
            cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        end

        // Random traffic: first half mostly draining, second half mostly stalled.
        for (int i = 0; i < 3000; i++) begin
            logic rdy;
            rdy = (i < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            cycle($urandom_range(0, 3) != 0, rand_inst(), $urandom & 32'hFFFFFFFC,
                  rdy, $urandom_range(0, 15) == 0);
        end
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
